// File: rtl/sram_window_reader_pkg.sv
// Shared types and default sizing for the SRAM window reader.
package sram_window_reader_pkg;

  localparam int DEF_A     = 7;
  localparam int DEF_W     = 16;
  localparam int DEF_K     = 3;
  localparam int DEF_IMG_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram_window_reader_addr_gen.sv
// Row/column walker for a K x K window; the address wraps modulo 2^A.
module window_addr_gen #(
  parameter int A     = 7,
  parameter int K     = 3,
  parameter int IMG_W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [A-1:0] base_addr,
  input  logic         step,
  output logic [A-1:0] sram_addr,
  output logic         at_last
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);
  localparam logic [A-1:0]  PITCH    = A'(IMG_W);

  logic [A-1:0]  base_q;
  logic [CW-1:0] r;
  logic [CW-1:0] c;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      base_q <= '0;
      r      <= '0;
      c      <= '0;
    end else if (load) begin
      base_q <= base_addr;
      r      <= '0;
      c      <= '0;
    end else if (step) begin
      if (c == LAST_IDX) begin
        c <= '0;
        r <= (r == LAST_IDX) ? '0 : r + CW'(1);
      end else begin
        c <= c + CW'(1);
      end
    end
  end

  always_comb begin
    sram_addr = base_q + A'(r) * PITCH + A'(c);
    at_last   = (r == LAST_IDX) && (c == LAST_IDX);
  end

endmodule

// File: rtl/sram_window_reader.sv
// Streams a K x K window out of a combinational-read SRAM over a valid/ready port.
// state | meaning
// IDLE  | waiting for start
// RUN   | capturing window words into the output register
// DRAIN | last word captured; waits for its handshake, then one settle cycle
module sram_window_reader
  import sram_window_reader_pkg::*;
#(
  parameter int A     = DEF_A,
  parameter int W     = DEF_W,
  parameter int K     = DEF_K,
  parameter int IMG_W = DEF_IMG_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [A-1:0] base_addr,
  output logic [A-1:0] sram_addr,
  input  logic [W-1:0] sram_data,
  output logic         sram_write,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  state_t state, state_nxt;
  logic   accept;
  logic   capture;
  logic   at_last;

  window_addr_gen #(
    .A     (A),
    .K     (K),
    .IMG_W (IMG_W)
  ) u_addr_gen (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (accept),
    .base_addr (base_addr),
    .step      (capture),
    .sram_addr (sram_addr),
    .at_last   (at_last)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (capture && at_last) state_nxt = DRAIN;
      DRAIN:   if (!out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == IDLE) && start;
    capture    = (state == RUN) && (!out_valid || out_ready);
    busy       = (state != IDLE);
    sram_write = 1'b0;
  end

  // The output register doubles as the skid stage: a stalled word holds until taken.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == DRAIN) && !out_valid;
      if (capture) begin
        out_data  <= sram_data;
        out_valid <= 1'b1;
        out_last  <= at_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_window_reader.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor checks each handshake.
module tb_sram_window_reader;

  localparam int A = 7;
  localparam int W = 16;

  typedef logic [W-1:0] stream_t [9];

  logic         CLK;
  logic         RST_N;
  logic         start;
  logic [A-1:0] base_addr;
  logic [A-1:0] sram_addr;
  logic [W-1:0] sram_data;
  logic         sram_write;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         done;

  logic [W-1:0] mem [2**A];
  logic [W:0]   exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_words  = 0;
  int n_done   = 0;

  sram_window_reader #(.A(A), .W(W), .K(3), .IMG_W(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .base_addr  (base_addr),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .sram_write (sram_write),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    for (int i = 0; i < 2**A; i++) mem[i] = W'(i);
  end
  assign sram_data = mem[sram_addr];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  task automatic push_stream(input stream_t s);
    for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), s[i]});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Returns during the cycle in which done is high (at its negedge).
  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done) return;
    end
    chk({name, " done timeout"}, 0, 1);
  endtask

  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) begin
      logic [W:0] e;
      n_words++;
      if (exp_q.size() == 0) begin
        chk("unexpected word", out_data, 'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("word data", out_data, e[W-1:0]);
        chk("word last", out_last, e[W]);
      end
    end
    if (RST_N && done) n_done++;
  end

  stream_t s10 = '{16'h10, 16'h11, 16'h12, 16'h18, 16'h19, 16'h1A, 16'h20, 16'h21, 16'h22};
  stream_t s7e = '{16'h7E, 16'h7F, 16'h00, 16'h06, 16'h07, 16'h08, 16'h0E, 16'h0F, 16'h10};
  stream_t s40 = '{16'h40, 16'h41, 16'h42, 16'h48, 16'h49, 16'h4A, 16'h50, 16'h51, 16'h52};
  stream_t s00 = '{16'h00, 16'h01, 16'h02, 16'h08, 16'h09, 16'h0A, 16'h10, 16'h11, 16'h12};
  stream_t s20 = '{16'h20, 16'h21, 16'h22, 16'h28, 16'h29, 16'h2A, 16'h30, 16'h31, 16'h32};
  stream_t s30 = '{16'h30, 16'h31, 16'h32, 16'h38, 16'h39, 16'h3A, 16'h40, 16'h41, 16'h42};

  initial begin
    int dn0;
    logic [2:0] exp3;
    RST_N = 1'b0; start = 1'b0; base_addr = '0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_data", out_data, 0);
    chk("rst sram_addr", sram_addr, 0);
    chk("sram_write", sram_write, 0);
    tick();
    RST_N = 1'b1;
    tick();

    // Basic window with cycle-exact busy/valid/done timing.
    push_stream(s10);
    start = 1'b1; base_addr = 7'h10;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge CLK);
      exp3 = {(k <= 11), (k >= 2 && k <= 10), (k == 12)};
      chk($sformatf("t1 busy/valid/done n+%0d", k), {busy, out_valid, done}, exp3);
      tick();
    end
    chk("t1 queue empty", exp_q.size(), 0);

    // Wrapping window, then a back-to-back start in the done cycle.
    push_stream(s7e);
    start = 1'b1; base_addr = 7'h7E;
    tick();
    start = 1'b0;
    wait_done("t2", 40);
    push_stream(s40);
    start = 1'b1; base_addr = 7'h40;
    tick();
    start = 1'b0;
    @(negedge CLK);
    chk("t2 back-to-back busy", busy, 1);
    wait_done("t2b", 40);
    chk("t2 queue empty", exp_q.size(), 0);
    tick();

    // Backpressure on the second word.
    n_words = 0;
    push_stream(s00);
    start = 1'b1; base_addr = 7'h00;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("t3 stall data %0d", k), out_data, 16'h01);
      chk($sformatf("t3 stall valid %0d", k), out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_done("t3", 40);
    chk("t3 word count", n_words, 9);
    chk("t3 queue empty", exp_q.size(), 0);
    tick();

    // Reset mid-window after the fourth word.
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, s00[i]});
    start = 1'b1; base_addr = 7'h00;
    tick();
    start = 1'b0;
    repeat (5) tick();
    RST_N = 1'b0;
    tick();
    @(negedge CLK);
    chk("t4 valid after reset", out_valid, 0);
    chk("t4 busy after reset", busy, 0);
    chk("t4 partial words consumed", exp_q.size(), 0);
    tick();
    RST_N = 1'b1;
    push_stream(s20);
    start = 1'b1; base_addr = 7'h20;
    tick();
    start = 1'b0;
    wait_done("t4", 40);
    chk("t4 queue empty", exp_q.size(), 0);
    tick();

    // Starts while busy must be ignored.
    dn0 = n_done;
    n_words = 0;
    push_stream(s30);
    start = 1'b1; base_addr = 7'h30;
    tick();
    for (int k = 1; k <= 11; k++) begin
      start = (k == 3 || k == 7 || k == 10 || k == 11);
      base_addr = 7'h50;
      tick();
    end
    start = 1'b0;
    repeat (6) tick();
    @(negedge CLK);
    chk("t5 done pulses", n_done - dn0, 1);
    chk("t5 word count", n_words, 9);
    chk("t5 busy idle", busy, 0);
    chk("t5 queue empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_window_reader.md
SRAM_WINDOW_READER -- requirements
Module: sram_window_reader

Interface
REQ-001 The module SHALL have parameter A, default 7, meaning SRAM address width.
REQ-002 The module SHALL have parameter W, default 16, meaning data word width.
REQ-003 The module SHALL have parameter K, default 3, meaning window edge (K x K words per window).
REQ-004 The module SHALL have parameter IMG_W, default 8, meaning row pitch in words.
REQ-005 The module SHALL have port CLK  input  1  meaning the single clock, with all state updated on its rising edge.
REQ-006 The module SHALL have port RST_N  input  1  meaning a synchronous, active-low reset.
REQ-007 The module SHALL have port start  input  1  meaning a window-read request.
REQ-008 The module SHALL have port base_addr  input  A  meaning the window top-left address, sampled with start.
REQ-009 The module SHALL have port sram_addr  output  A  meaning the SRAM read address.
REQ-010 The module SHALL have port sram_data  input  W  meaning SRAM read data, combinational from sram_addr.
REQ-011 The module SHALL have port sram_write  output  1  meaning the SRAM write enable, tied 0.
REQ-012 The module SHALL have port out_data  output  W  meaning the registered window word.
REQ-013 The module SHALL have port out_valid  output  1  meaning out_data is valid.
REQ-014 The module SHALL have port out_ready  input  1  meaning the downstream consumer accepts.
REQ-015 The module SHALL have port out_last  output  1  meaning out_data is word K*K-1 of the window.
REQ-016 The module SHALL have port busy  output  1  meaning the state is not IDLE.
REQ-017 The module SHALL have port done  output  1  meaning a one-cycle pulse after the window completes.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-019 In IDLE, start=1 SHALL latch base_addr, clear the row/col counters r and c, and enter RUN; start outside IDLE SHALL be ignored.
REQ-020 sram_addr SHALL equal (base + r*IMG_W + c) mod 2^A, combinational from registered state, and wrap without error.
REQ-021 In RUN, when !out_valid || out_ready, the block SHALL capture sram_data into out_data, set out_valid, and advance c, wrapping c to 0 and incrementing r at c=K-1.
REQ-022 out_last SHALL be set with the capture at r=K-1, c=K-1, after which the FSM SHALL enter DRAIN.
REQ-023 When out_valid=1 and out_ready=0, out_data, out_last and the counters SHALL hold.
REQ-024 A handshake with out_valid && out_ready and no new capture SHALL clear out_valid.
REQ-025 In DRAIN, a handshake on the last word SHALL clear out_valid and out_last, enter IDLE, and pulse done for exactly one cycle.
REQ-026 With start in cycle n and out_ready tied 1: busy SHALL be high in n+1..n+11, out_valid SHALL be high in n+2..n+10, and done SHALL be high in n+12.
REQ-027 Throughput SHALL be one word per cycle with no bubbles under continuous out_ready.
REQ-028 Back-to-back windows SHALL be possible, with start accepted in the same cycle that done is high.

Reset
REQ-029 RST_N=0 at a clock edge SHALL force IDLE, r=c=0, out_valid=0, out_last=0, out_data=0, done=0 and busy=0, including mid-window, and the partial window SHALL be discarded.
REQ-030 sram_addr SHALL equal the reset value of the base register, which is 0, while in reset.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and default parameter constants (A, W, K, IMG_W).
REQ-032 Address/counter generation SHALL be one sub-module, window_addr_gen, containing the r/c counters and the address adder.

Verification
REQ-033 The bench SHALL model the SRAM with memory[i]=i, so word value equals address.
REQ-034 base=0x10, out_ready=1 -> the stream SHALL be 0x10,0x11,0x12,0x18,0x19,0x1A,0x20,0x21,0x22, with out_last on 0x22, and done in cycle n+12.
REQ-035 base=0x7E -> the stream SHALL be 0x7E,0x7F,0x00,0x06,0x07,0x08,0x0E,0x0F,0x10 (wrap).
REQ-036 base=0x00 with out_ready low for 3 cycles after the 2nd word -> the 2nd word (0x01) SHALL hold stable for those cycles, with no loss or duplication and 9 words total.
REQ-037 RST_N=0 asserted after the 4th word -> out_valid=0 and busy=0 next cycle, and a new start with base=0x20 SHALL yield 0x20 first.
REQ-038 start pulses while busy -> the start SHALL be ignored, exactly one window SHALL be produced, and exactly one done pulse SHALL occur.
